// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage.
// Drives registered read addresses into a fixed-latency instruction memory,
// tracks each outstanding read with an in-flight {valid, pc} tag pipeline, and
// buffers returned words with their PCs in a small FIFO presented to decode
// through a valid/ready handshake. A redirect flushes the FIFO and all in-flight
// tags and restarts fetch at the new target.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN adds the misaligned_fault port.
// A misaligned redirect then stalls fetch with a sticky fault instead of
// silently aligning the target.
module instr_fetch_unit #(
    parameter int unsigned       XLEN        = 32,
    parameter logic [XLEN-1:0]   RESET_PC    = '0,
    parameter int unsigned       FIFO_DEPTH  = 4,
    parameter int unsigned       MEM_LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic [XLEN-1:0]  mem_addr,
    input  logic [31:0]      mem_rdata,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             instr_valid,
    output logic [31:0]      instr_bits,
    output logic [XLEN-1:0]  instr_pc,
    input  logic             instr_ready
`ifdef FETCH_MISALIGN_TRAP_EN
   ,output logic             misaligned_fault
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IF_W  = $clog2(MEM_LATENCY + 1);

    // Address / fetch PC registers
    logic [XLEN-1:0]        mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]        fetch_pc_q, fetch_pc_d;

    // In-flight tag pipeline: stage 0 is the read issued at the last edge,
    // stage MEM_LATENCY-1 is the read whose data is on mem_rdata now.
    logic [MEM_LATENCY-1:0] tag_v_q, tag_v_d;
    logic [XLEN-1:0]        tag_pc_q [MEM_LATENCY];
    logic [XLEN-1:0]        tag_pc_d [MEM_LATENCY];

    // Fetched-word FIFO
    logic [31:0]            fifo_bits_q [FIFO_DEPTH];
    logic [XLEN-1:0]        fifo_pc_q   [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;

    // Sticky misaligned-redirect fault (never set unless the trap is enabled)
    logic                   fault_q, fault_d;

    // Combinational helpers
    logic [IF_W-1:0]        inflight_cnt;
    logic                   credit_ok;
    logic                   push;
    logic                   push_en;
    logic                   pop;
    logic                   issue;
    logic                   redirect_bad;
    logic [XLEN-1:0]        redirect_aligned;
    logic                   new_tag_v;
    logic [XLEN-1:0]        new_tag_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign redirect_bad     = |redirect_pc[1:0];
    assign misaligned_fault = fault_q;
`else
    assign redirect_bad     = 1'b0;
`endif

    assign redirect_aligned = redirect_pc & ~XLEN'(3);

    // Outputs come straight from registered state; no memory-to-decode bypass
    assign mem_addr    = mem_addr_q;
    assign instr_valid = (count_q != '0);
    assign instr_bits  = fifo_bits_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];

    assign push    = tag_v_q[MEM_LATENCY-1];
    assign push_en = push && !redirect_valid;
    assign pop     = instr_valid && instr_ready;

    // Count outstanding reads for the issue credit check
    always_comb begin
        inflight_cnt = '0;
        for (int unsigned k = 0; k < MEM_LATENCY; k++) begin
            inflight_cnt = inflight_cnt + IF_W'(tag_v_q[k]);
        end
    end

    // Credit ignores a same-edge pop, so buffered + outstanding never exceeds the FIFO
    assign credit_ok = (32'(count_q) + 32'(inflight_cnt)) < 32'(FIFO_DEPTH);
    assign issue     = credit_ok && !fault_q;

    // Next-state: redirect overrides pop, push and normal issue
    always_comb begin
        mem_addr_d = mem_addr_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        fault_d    = fault_q;
        new_tag_v  = 1'b0;
        new_tag_pc = '0;

        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (redirect_bad) begin
                fault_d = 1'b1;
            end else begin
                fault_d    = 1'b0;
                mem_addr_d = redirect_aligned;
                fetch_pc_d = redirect_aligned + XLEN'(4);
                new_tag_v  = 1'b1;
                new_tag_pc = redirect_aligned;
            end
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (issue) begin
                mem_addr_d = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                new_tag_v  = 1'b1;
                new_tag_pc = fetch_pc_q;
            end
        end
    end

    // Tag pipeline shift; a redirect invalidates every older tag so stale data is dropped
    always_comb begin
        tag_v_d[0]  = new_tag_v;
        tag_pc_d[0] = new_tag_pc;
        for (int unsigned k = 1; k < MEM_LATENCY; k++) begin
            tag_v_d[k]  = redirect_valid ? 1'b0 : tag_v_q[k-1];
            tag_pc_d[k] = tag_pc_q[k-1];
        end
    end

    // State registers; reset issues the RESET_PC read immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr_q <= RESET_PC;
            fetch_pc_q <= RESET_PC + XLEN'(4);
            tag_v_q    <= MEM_LATENCY'(1);
            for (int unsigned k = 0; k < MEM_LATENCY; k++) begin
                tag_pc_q[k] <= (k == 0) ? RESET_PC : '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr_d;
            fetch_pc_q <= fetch_pc_d;
            tag_v_q    <= tag_v_d;
            for (int unsigned k = 0; k < MEM_LATENCY; k++) begin
                tag_pc_q[k] <= tag_pc_d[k];
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads zero out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_bits_q[i] <= '0;
                fifo_pc_q[i]   <= '0;
            end
        end else if (push_en) begin
            fifo_bits_q[wr_ptr_q] <= mem_rdata;
            fifo_pc_q[wr_ptr_q]   <= tag_pc_q[MEM_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based transaction model of the fetch stage.
module tb_instr_fetch_unit;

    localparam logic [31:0] RPC   = 32'h100;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LAT   = 2;
    localparam logic [31:0] MAGIC = 32'hA5A5_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr_bits;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned_fault;
`endif

    instr_fetch_unit #(
        .XLEN        (32),
        .RESET_PC    (RPC),
        .FIFO_DEPTH  (DEPTH),
        .MEM_LATENCY (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_bits     (instr_bits),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
       ,.misaligned_fault (misaligned_fault)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory: address driven at edge i is answered for sampling at edge i+2
    logic [31:0] mem_addr_d1;
    always @(posedge clk) mem_addr_d1 <= mem_addr;
    assign mem_rdata = mem_addr_d1 ^ MAGIC;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // Transaction model: reads in flight carry the edge on which their data lands
    typedef struct {
        logic [31:0] pc;
        int unsigned due;
    } fl_t;

    logic [31:0] mq[$];
    fl_t         fl[$];
    logic [31:0] m_addr, m_next, m_a;
    bit          m_fault = 1'b0;
    bit          m_on    = 1'b0;
    int unsigned cyc     = 0;
    int unsigned m_used;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            fl.delete();
            fl.push_back('{pc: RPC, due: cyc + LAT});
            m_addr  = RPC;
            m_next  = RPC + 32'd4;
            m_fault = 1'b0;
            m_on    = 1'b1;
        end else if (m_on) begin
            if (redirect_valid) begin
                mq.delete();
                fl.delete();
                if (TRAP && redirect_pc[1:0] != 2'b00) begin
                    m_fault = 1'b1;
                end else begin
                    m_fault = 1'b0;
                    m_a     = redirect_pc & ~32'd3;
                    m_addr  = m_a;
                    m_next  = m_a + 32'd4;
                    fl.push_back('{pc: m_a, due: cyc + LAT});
                end
            end else begin
                m_used = mq.size() + fl.size();
                if (mq.size() != 0 && instr_ready) void'(mq.pop_front());
                while (fl.size() != 0 && fl[0].due == cyc) begin
                    mq.push_back(fl[0].pc);
                    void'(fl.pop_front());
                end
                if (!m_fault && m_used < DEPTH) begin
                    m_addr = m_next;
                    fl.push_back('{pc: m_next, due: cyc + LAT});
                    m_next = m_next + 32'd4;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_on) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("instr_valid", 32'(instr_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("instr_pc", instr_pc, mq[0]);
                chk("instr_bits", instr_bits, mq[0] ^ MAGIC);
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            chk("misaligned_fault", 32'(misaligned_fault), 32'(m_fault));
`endif
        end
    end

    // Bounded wait for the next valid head, then pin its PC
    task automatic wait_valid(input logic [31:0] exp_pc, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (instr_valid) seen = 1'b1;
        end
        chk({nm, "_timeout"}, 32'(seen), 32'd1);
        if (seen) chk(nm, instr_pc, exp_pc);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_bits", instr_bits, 32'h0);
        chk("rst_mem_addr", mem_addr, RPC);
        rst = 1'b0;

        // Stream from RESET_PC, first valid two edges after the reset edge
        @(negedge clk);
        chk("early_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("first_valid", 32'(instr_valid), 32'd1);
        chk("first_pc", instr_pc, 32'h100);
        chk("first_bits", instr_bits, 32'hA5A5_0100);
        @(negedge clk);
        chk("second_pc", instr_pc, 32'h104);

        // Backpressure fills the buffer and freezes fetch
        instr_ready = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_mem_addr", mem_addr, 32'h110);
        chk("stall_head_pc", instr_pc, 32'h104);
        chk("stall_valid", 32'(instr_valid), 32'd1);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("resume_pc", instr_pc, 32'h108);

        // Redirect with words buffered and reads in flight, same edge as a pop
        instr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        instr_ready    = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("redir_flush_valid", 32'(instr_valid), 32'd0);
        wait_valid(32'h400, "redir_400");
        repeat (3) @(negedge clk);

        // Back-to-back redirects: only the last one survives
        redirect_valid = 1'b1;
        redirect_pc    = 32'h600;
        @(negedge clk);
        chk("b2b_valid0", 32'(instr_valid), 32'd0);
        redirect_pc = 32'h800;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("b2b_valid1", 32'(instr_valid), 32'd0);
        wait_valid(32'h800, "b2b_800");
        @(negedge clk);
        chk("b2b_804", instr_pc, 32'h804);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 32'h402;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("fault_set", 32'(misaligned_fault), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fault_hold_valid", 32'(instr_valid), 32'd0);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("fault_clear", 32'(misaligned_fault), 32'd0);
        wait_valid(32'h500, "fault_500");
`else
        wait_valid(32'h400, "misalign_400");
        @(negedge clk);
        chk("misalign_404", instr_pc, 32'h404);
`endif

        // Address wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_valid(32'hFFFF_FFF8, "wrap_fff8");
        @(negedge clk);
        chk("wrap_fffc", instr_pc, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_0", instr_pc, 32'h0);

        // Reset wins over a simultaneous redirect
        rst            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h900;
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        chk("rst_redir_valid", 32'(instr_valid), 32'd0);
        chk("rst_redir_addr", mem_addr, RPC);
        wait_valid(RPC, "rst_redir_first");

        // Randomized traffic
        repeat (3000) begin
            @(negedge clk);
            rst            = ($urandom_range(0, 499) == 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = $urandom() & ~32'd3;
                1:       redirect_pc = 32'hFFFF_FFF0 | ($urandom_range(0, 15) & ~32'd3);
                2:       redirect_pc = $urandom();
                default: redirect_pc = 32'h1000 + $urandom_range(0, 63);
            endcase
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
